// File: rtl/cpu_bus_pkg.sv
// Shared types for the SRAM-like bus arbiter: FSM states, grant encoding,
// transfer-size codes and the latched request record.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    localparam logic GRANT_INST = 1'b0;
    localparam logic GRANT_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_cmd_t;

    function automatic sram_cmd_t pack_cmd(input logic        wr,
                                           input logic [1:0]  size,
                                           input logic [31:0] addr,
                                           input logic [31:0] wdata);
        sram_cmd_t c;
        c.wr    = wr;
        c.size  = size;
        c.addr  = addr;
        c.wdata = wdata;
        return c;
    endfunction

endpackage

// File: rtl/sram_like_arbiter_if.sv
// One SRAM-like port: request fields flow master->slave, accept/response
// flow slave->master.
interface sram_like_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    modport master (
        output req, wr, size, addr, wdata,
        input  rdata, addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output rdata, addr_ok, data_ok
    );
endinterface

// File: rtl/arb_pick2.sv
// Combinational two-way picker. Tie-break: data always wins by default;
// with SRAM_ARB_RR_EN defined the port that did not win last time wins.
module arb_pick2
    import cpu_bus_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic valid,
    output logic grant
);

`ifndef SRAM_ARB_RR_EN
    // Fixed priority never looks at history.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        valid = req_i | req_d;
        grant = GRANT_INST;
        if (req_i && req_d) begin
`ifdef SRAM_ARB_RR_EN
            grant = ~last_grant;
`else
            grant = GRANT_DATA;
`endif
        end else if (req_d) begin
            grant = GRANT_DATA;
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like memory port between instruction and data ports with
// one transaction outstanding. Tie policy selectable via SRAM_ARB_RR_EN.
module sram_like_arbiter
    import cpu_bus_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    sram_like_arbiter_if.slave         inst_bus,
    sram_like_arbiter_if.slave         data_bus,
    sram_like_arbiter_if.master        mem_bus
);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_grant_q, last_grant_d;
    sram_cmd_t  cmd_q, cmd_d;

    sram_cmd_t  inst_cmd, data_cmd;
    logic       pick_valid, pick_grant;
    logic       inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok;

    assign inst_cmd = pack_cmd(inst_bus.wr, inst_bus.size, inst_bus.addr, inst_bus.wdata);
    assign data_cmd = pack_cmd(data_bus.wr, data_bus.size, data_bus.addr, data_bus.wdata);

    arb_pick2 u_pick (
        .req_i      (inst_bus.req),
        .req_d      (data_bus.req),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .grant      (pick_grant)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cmd_d        = cmd_q;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d      = ST_REQ;
                    owner_d      = pick_grant;
                    last_grant_d = pick_grant;
                    if (pick_grant == GRANT_DATA) begin
                        data_addr_ok = 1'b1;
                        cmd_d        = data_cmd;
                    end else begin
                        inst_addr_ok = 1'b1;
                        cmd_d        = inst_cmd;
                    end
                end
            end
            ST_REQ: begin
                if (mem_bus.addr_ok) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // Responses outside RESP are strays and fall through untouched.
                if (mem_bus.data_ok) begin
                    state_d = ST_IDLE;
                    if (owner_q == GRANT_DATA) begin
                        data_data_ok = 1'b1;
                    end else begin
                        inst_data_ok = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A reset cycle aborts the transaction: nothing is accepted or completed.
        if (rst) begin
            inst_addr_ok = 1'b0;
            data_addr_ok = 1'b0;
            inst_data_ok = 1'b0;
            data_data_ok = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= GRANT_INST;
            last_grant_q <= GRANT_INST;
            cmd_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cmd_q        <= cmd_d;
        end
    end

    assign mem_bus.req   = (state_q == ST_REQ);
    assign mem_bus.wr    = cmd_q.wr;
    assign mem_bus.size  = cmd_q.size;
    assign mem_bus.addr  = cmd_q.addr;
    assign mem_bus.wdata = cmd_q.wdata;

    assign inst_bus.addr_ok = inst_addr_ok;
    assign data_bus.addr_ok = data_addr_ok;
    assign inst_bus.data_ok = inst_data_ok;
    assign data_bus.data_ok = data_data_ok;
    assign inst_bus.rdata   = mem_bus.rdata;
    assign data_bus.rdata   = mem_bus.rdata;

endmodule
